// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC stage: state and redirect-select encodings,
// default reset vector, sequential increment and the immediate sign extender.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_sequencer_target_sel.sv
// Next-PC candidates (seq/branch/jump/register-jump) and the fixed
// jr > jump > branch > seq priority; purely combinational.
module pc_target_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        redirect_o,
  output logic        misaligned_o
);

  logic [31:0] seq_pc, br_pc, j_pc, jr_pc;
  sel_e        sel;

  assign seq_pc = pc_i + PC_INCR;
  assign br_pc  = seq_pc + (sign_ext16(branch_imm_i) << 2);
  assign j_pc   = {seq_pc[31:28], jump_index_i, 2'b00};
  // Misaligned register targets are forced onto a word boundary.
  assign jr_pc  = {jr_target_i[31:2], 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (jr_i)                sel = SEL_JR;
    else if (jump_i)         sel = SEL_J;
    else if (branch_taken_i) sel = SEL_BR;
  end

  always_comb begin
    next_pc_o = seq_pc;
    unique case (sel)
      SEL_BR:  next_pc_o = br_pc;
      SEL_J:   next_pc_o = j_pc;
      SEL_JR:  next_pc_o = jr_pc;
      default: next_pc_o = seq_pc;
    endcase
  end

  assign pc_plus4_o   = seq_pc;
  assign redirect_o   = (sel != SEL_SEQ);
  assign misaligned_o = jr_i & (jr_target_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC register with imem valid/ready handshake; redirects seen while fetch is
// blocked are latched once and applied when the block clears.
//   state  | meaning
//   S_BOOT | first cycle after reset, no fetch request
//   S_RUN  | fetching, pc advances on accepted cycles
//   S_HOLD | blocked with a latched redirect waiting to be applied
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        addr_err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] next_pc;
  logic        redirect, misaligned, accept;

  pc_target_sel u_target_sel (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken),
    .branch_imm_i   (branch_imm),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .jr_i           (jr),
    .jr_target_i    (jr_target),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc),
    .redirect_o     (redirect),
    .misaligned_o   (misaligned)
  );

  // A stall overrides a ready memory.
  assign accept = imem_ready & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    pc_valid = 1'b0;
    addr_err = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        pc_valid = 1'b1;
        addr_err = misaligned & ~reset;
        if (accept) begin
          pc_d = next_pc;
        end else if (redirect) begin
          tgt_d   = next_pc;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        pc_valid = 1'b1;
        if (accept) begin
          pc_d    = tgt_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == S_HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios followed by random traffic, all checked against a
// cycle-level reference model of the PC stage.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, branch_taken, jump, jr;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4;
  logic        pc_valid, redirect_pending, addr_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit          m_known   = 1'b0;
  bit          m_booting = 1'b1;
  bit          m_pend    = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_tgt     = 32'h0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .branch_taken     (branch_taken),
    .branch_imm       (branch_imm),
    .jump             (jump),
    .jump_index       (jump_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .addr_err         (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs mid-cycle, check outputs, advance model and DUT.
  task automatic step(input bit rst, input bit stl, input bit rdy,
                      input bit br, input logic [15:0] imm,
                      input bit jmp, input logic [25:0] idx,
                      input bit jrr, input logic [31:0] jt);
    logic [31:0] p4, t;
    bit          redir;
    @(negedge clk);
    reset = rst; stall = stl; imem_ready = rdy;
    branch_taken = br; branch_imm = imm;
    jump = jmp; jump_index = idx; jr = jrr; jr_target = jt;
    #1;
    p4 = m_pc + 32'd4;
    if (m_known) begin
      chk("pc",       pc, m_pc);
      chk("pc_plus4", pc_plus4, p4);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, !m_booting});
      chk("pending",  {31'd0, redirect_pending}, {31'd0, m_pend});
      chk("addr_err", {31'd0, addr_err},
          {31'd0, (!rst && !m_booting && !m_pend && jrr && jt[1:0] != 2'b00)});
    end
    redir = jrr || jmp || br;
    if (jrr)      t = jt & 32'hFFFF_FFFC;
    else if (jmp) t = {p4[31:28], idx, 2'b00};
    else if (br)  t = p4 + 32'($signed(imm)) * 32'd4;
    else          t = p4;
    if (rst) begin
      m_known = 1'b1; m_booting = 1'b1; m_pend = 1'b0; m_pc = 32'h0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_pend) begin
      if (rdy && !stl) begin m_pc = m_tgt; m_pend = 1'b0; end
    end else if (rdy && !stl) begin
      m_pc = t;
    end else if (redir) begin
      m_pend = 1'b1; m_tgt = t;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, rdy, 0, 16'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic go_jr(input logic [31:0] a);
    step(0, 0, 1, 0, 16'h0, 0, 26'h0, 1, a);
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] v);
    #2 chk(tag, pc, v);
  endtask

  initial begin
    reset = 1; stall = 0; imem_ready = 0; branch_taken = 0; branch_imm = 0;
    jump = 0; jump_index = 0; jr = 0; jr_target = 0;

    step(1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    #2 chk("boot_valid", {31'd0, pc_valid}, 32'd0);
    idle(1);
    expect_pc("boot_pc", 32'h0);
    idle(1);
    expect_pc("seq1", 32'h4);
    idle(1);
    expect_pc("seq2", 32'h8);

    go_jr(32'h100);
    step(0, 0, 1, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0);
    expect_pc("br_back", 32'hF4);
    go_jr(32'hFFFF_FFFC);
    step(0, 0, 1, 1, 16'h0001, 0, 26'h0, 0, 32'h0);
    expect_pc("br_wrap", 32'h4);

    go_jr(32'h1000_0008);
    step(0, 0, 1, 1, 16'h0010, 1, 26'h10, 1, 32'h400);
    expect_pc("prio_jr", 32'h400);
    go_jr(32'h1000_0008);
    step(0, 0, 1, 0, 16'h0, 1, 26'h10, 0, 32'h0);
    expect_pc("jump", 32'h1000_0040);

    go_jr(32'h20);
    step(0, 0, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0);
    step(0, 0, 0, 0, 16'h0, 1, 26'h3F, 0, 32'h0);
    step(0, 1, 1, 0, 16'h0, 0, 26'h0, 1, 32'h80);
    expect_pc("hold_pc", 32'h20);
    chk("hold_pend", {31'd0, redirect_pending}, 32'd1);
    idle(1);
    expect_pc("hold_release", 32'h34);
    chk("hold_clear", {31'd0, redirect_pending}, 32'd0);

    go_jr(32'h0000_0203);
    expect_pc("jr_misalign", 32'h200);

    step(0, 0, 0, 1, 16'h0040, 0, 26'h0, 0, 32'h0);
    step(1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    expect_pc("rst_hold_pc", 32'h0);
    chk("rst_hold_pend", {31'd0, redirect_pending}, 32'd0);
    idle(1);
    idle(1);
    expect_pc("rst_discard", 32'h4);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 70,
           $urandom_range(99) < 25, 16'($urandom),
           $urandom_range(99) < 15, 26'($urandom),
           $urandom_range(99) < 15, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
